// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for sync_fifo_param.
//   master : drives write, read, data_in; observes data, count and flags
//   slave  : the FIFO; drives data_out, count, status flags and error pulses
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int PW = $clog2(DEPTH);

    logic              write;
    logic              read;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [PW:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output write, read, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write, read, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with parametrised width/depth, occupancy
// count, almost-full/almost-empty thresholds and one-cycle overflow/underflow
// pulses.
//   clk   : rising-edge clock for all state
//   reset : synchronous, active-high; wins over read/write in the same cycle
//   bus   : sync_fifo_param_if.slave (write/read/data_in in; data_out, count,
//           full, empty, almost_full, almost_empty, overflow, underflow out)
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    sync_fifo_param_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [PW:0]       count_q;
    logic [DATA_W-1:0] data_out_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_c;
    logic              empty_c;
    logic              wr_ok;
    logic              rd_ok;

    // Flags decode only the registered count, so acceptance never depends on
    // the other request in the same cycle.
    assign full_c  = (count_q == (PW+1)'(DEPTH));
    assign empty_c = (count_q == '0);
    assign wr_ok   = bus.write && !full_c;
    assign rd_ok   = bus.read  && !empty_c;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wp] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp          <= '0;
            rp          <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.write && full_c;
            underflow_q <= bus.read  && empty_c;
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                rp         <= rp + 1'b1;
                data_out_q <= mem[rp];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= (PW+1)'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= (PW+1)'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param with DATA_W=8,
// DEPTH=4, AF_LEVEL=3, AE_LEVEL=1. Expected values are hand-computed.
module tb_sync_fifo_param;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(4)) bus ();

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [7:0] din);
        bus.write   = wr;
        bus.read    = rd;
        bus.data_in = din;
    endtask

    task automatic check_status(input string tag, input int cnt, input int emp,
                                input int ful, input int ae, input int af);
        check_val({tag, ".count"},        int'(bus.count),        cnt);
        check_val({tag, ".empty"},        int'(bus.empty),        emp);
        check_val({tag, ".full"},         int'(bus.full),         ful);
        check_val({tag, ".almost_empty"}, int'(bus.almost_empty), ae);
        check_val({tag, ".almost_full"},  int'(bus.almost_full),  af);
    endtask

    task automatic check_err(input string tag, input int ovf, input int unf);
        check_val({tag, ".overflow"},  int'(bus.overflow),  ovf);
        check_val({tag, ".underflow"}, int'(bus.underflow), unf);
    endtask

    logic [7:0] fill_d [4];
    int         fill_af [4];
    int         fill_ae [4];
    logic [7:0] wrap_exp [6];

    initial begin
        n_vec = 0;
        n_err = 0;
        fill_d   = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill_ae  = '{1, 0, 0, 0};
        fill_af  = '{0, 0, 1, 1};
        wrap_exp = '{8'hB0, 8'hB1, 8'hA0, 8'hA1, 8'hA2, 8'hA3};

        // Reset, then idle
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        check_status("rst", 0, 1, 0, 1, 0);
        check_val("rst.data_out", int'(bus.data_out), 0);
        check_err("rst", 0, 0);
        reset = 1'b0;
        step();
        check_status("idle", 0, 1, 0, 1, 0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, fill_d[i]);
            step();
            check_status($sformatf("fill%0d", i), i + 1, 0, (i == 3) ? 1 : 0,
                         fill_ae[i], fill_af[i]);
            check_err($sformatf("fill%0d", i), 0, 0);
        end

        // Overfill
        drive(1'b1, 1'b0, 8'h55);
        step();
        check_status("ovf", 4, 0, 1, 0, 1);
        check_err("ovf", 1, 0);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check_err("ovf_end", 0, 0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check_val($sformatf("drain%0d.data", i), int'(bus.data_out), int'(fill_d[i]));
            check_val($sformatf("drain%0d.count", i), int'(bus.count), 3 - i);
        end
        check_status("drained", 0, 1, 0, 1, 0);

        // Underflow holds data_out
        step();
        check_err("unf", 0, 1);
        check_val("unf.data_out", int'(bus.data_out), 8'h44);
        check_val("unf.count", int'(bus.count), 0);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check_err("unf_end", 0, 0);

        // Wrap-around with simultaneous access
        drive(1'b1, 1'b0, 8'hB0);
        step();
        drive(1'b1, 1'b0, 8'hB1);
        step();
        check_val("pre.count", int'(bus.count), 2);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 8'hA0 + 8'(i));
            step();
            check_val($sformatf("wrap%0d.data", i), int'(bus.data_out), int'(wrap_exp[i]));
            check_val($sformatf("wrap%0d.count", i), int'(bus.count), 2);
            check_err($sformatf("wrap%0d", i), 0, 0);
        end
        drive(1'b0, 1'b1, 8'h00);
        step();
        check_val("wrap_tail0", int'(bus.data_out), 8'hA4);
        step();
        check_val("wrap_tail1", int'(bus.data_out), 8'hA5);
        check_status("wrap_done", 0, 1, 0, 1, 0);

        // Full + read + write
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'hC0 + 8'(i));
            step();
        end
        check_val("cf.full", int'(bus.full), 1);
        drive(1'b1, 1'b1, 8'h99);
        step();
        check_val("cf.data", int'(bus.data_out), 8'hC0);
        check_err("cf", 1, 0);
        check_status("cf", 3, 0, 0, 0, 1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check_val($sformatf("cf_rd%0d", i), int'(bus.data_out), 8'hC0 + i);
        end
        check_status("cf_done", 0, 1, 0, 1, 0);

        // Empty + read + write
        drive(1'b1, 1'b1, 8'h77);
        step();
        check_err("ce", 0, 1);
        check_status("ce", 1, 0, 0, 1, 0);
        check_val("ce.data_hold", int'(bus.data_out), 8'hC3);
        drive(1'b0, 1'b1, 8'h00);
        step();
        check_val("ce.data", int'(bus.data_out), 8'h77);
        check_err("ce_rd", 0, 0);
        check_val("ce_rd.count", int'(bus.count), 0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'hD0 + 8'(i));
            step();
        end
        check_val("mid.count", int'(bus.count), 3);
        drive(1'b1, 1'b1, 8'hEE);
        reset = 1'b1;
        step();
        check_status("mid_rst", 0, 1, 0, 1, 0);
        check_val("mid_rst.data_out", int'(bus.data_out), 0);
        check_err("mid_rst", 0, 0);
        reset = 1'b0;
        drive(1'b0, 1'b1, 8'h00);
        step();
        check_err("post_rst", 0, 1);
        check_val("post_rst.count", int'(bus.count), 0);
        check_val("post_rst.data_out", int'(bus.data_out), 0);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check_err("post_rst_end", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
